// File: rtl/data_bus_responder_if.sv
// CPU data-bus bundle: registered word address and write strobe from the CPU,
// combinational read data back.
interface data_bus_responder_if;
   logic [15:0] dataAddress;
   logic [31:0] wrData;
   logic        dataWrEn;
   logic [31:0] rdData;

   modport master (output dataAddress, output wrData, output dataWrEn, input rdData);
   modport slave  (input dataAddress, input wrData, input dataWrEn, output rdData);
endinterface

// File: rtl/data_bus_responder.sv
// Memory-mapped responder on the CPU data bus: word RAM, LED register,
// 8-entry TX FIFO feeding an 8N1 UART transmitter, free-running cycle counter.
module data_bus_responder #(
   parameter int unsigned RAM_WORDS    = 256,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                 clk,
   input  logic                 Rst,
   data_bus_responder_if.slave  bus,
   output logic [7:0]           leds,
   output logic                 txd
);

   localparam int unsigned AW         = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int unsigned TW         = $clog2(CLKS_PER_BIT);
   localparam int unsigned FIFO_DEPTH = 8;
   localparam logic [15:0] ADDR_LED    = 16'h8000;
   localparam logic [15:0] ADDR_TX     = 16'h8001;
   localparam logic [15:0] ADDR_STATUS = 16'h8002;
   localparam logic [15:0] ADDR_CYCLES = 16'h8003;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   logic [31:0]   ram [RAM_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [2:0]    wr_ptr, rd_ptr;
   logic [3:0]    count;
   logic          tx_toggle;
   uart_state_t   state;
   logic [TW-1:0] bit_timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [31:0]   cycles;
   logic [31:0]   rd_word;

   logic          ram_sel, wr_ram, wr_led, wr_cyc;
   logic [AW-1:0] ram_idx;
   logic          push, pop, bit_end, busy, full, empty;

   assign ram_sel = 32'(bus.dataAddress) < RAM_WORDS;
   assign ram_idx = bus.dataAddress[AW-1:0];
   assign wr_ram  = bus.dataWrEn && ram_sel;
   assign wr_led  = bus.dataWrEn && (bus.dataAddress == ADDR_LED);
   assign wr_cyc  = bus.dataWrEn && (bus.dataAddress == ADDR_CYCLES);

   assign full    = (count == 4'(FIFO_DEPTH));
   assign empty   = (count == 4'd0);
   assign busy    = (state != S_IDLE);
   assign bit_end = (bit_timer == TW'(CLKS_PER_BIT - 1));

   // A push needs a fresh toggle value, so a held write only ever queues one byte.
   assign push = bus.dataWrEn && (bus.dataAddress == ADDR_TX) &&
                 (bus.wrData[8] != tx_toggle) && !full;
   assign pop  = (state == S_IDLE) && !empty;

   always_ff @(posedge clk) begin
      if (wr_ram) ram[ram_idx] <= bus.wrData;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.wrData[7:0];
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) leds <= '0;
      else if (wr_led) leds <= bus.wrData[7:0];
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) cycles <= '0;
      else if (wr_cyc) cycles <= bus.wrData;
      else cycles <= cycles + 32'd1;
   end

   // FIFO bookkeeping and the UART transmitter; txd is updated on the same
   // edge as the state change so it never glitches between bits.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         tx_toggle <= 1'b0;
         state     <= S_IDLE;
         txd       <= 1'b1;
         bit_timer <= '0;
         bit_idx   <= '0;
         shift     <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + 3'd1;
            tx_toggle <= bus.wrData[8];
         end
         if (pop) rd_ptr <= rd_ptr + 3'd1;
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase

         case (state)
            S_IDLE: begin
               txd       <= 1'b1;
               bit_timer <= '0;
               if (pop) begin
                  shift <= fifo_mem[rd_ptr];
                  txd   <= 1'b0;
                  state <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  bit_idx   <= '0;
                  txd       <= shift[0];
                  shift     <= {1'b0, shift[7:1]};
                  state     <= S_DATA;
               end else begin
                  bit_timer <= bit_timer + TW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                  end
               end else begin
                  bit_timer <= bit_timer + TW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  state     <= S_IDLE;
               end else begin
                  bit_timer <= bit_timer + TW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

   // Zero-latency read mux; unmapped addresses read as zero.
   always_comb begin
      rd_word = '0;
      if (ram_sel) begin
         rd_word = ram[ram_idx];
      end else begin
         case (bus.dataAddress)
            ADDR_LED:    rd_word = {24'b0, leds};
            ADDR_TX:     rd_word = {23'b0, tx_toggle, 8'b0};
            ADDR_STATUS: rd_word = {25'b0, count, busy, full, empty};
            ADDR_CYCLES: rd_word = cycles;
            default:     rd_word = '0;
         endcase
      end
   end

   assign bus.rdData = rd_word;

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios plus random bus traffic,
// checked against a bench-side register/RAM model and a UART frame receiver.
module tb_data_bus_responder;

   localparam int unsigned CPB   = 8;
   localparam int unsigned FRAME = 10 * CPB;
   localparam int unsigned WORDS = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] leds;
   logic       txd;

   data_bus_responder_if bus();

   data_bus_responder #(.RAM_WORDS(WORDS), .CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .Rst  (rst),
      .bus  (bus),
      .leds (leds),
      .txd  (txd)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference state
   logic [31:0] ram_m [WORDS];
   bit          ram_v [WORDS];
   logic [7:0]  leds_m   = 8'h00;
   logic        toggle_m = 1'b0;
   int          pushes   = 0;
   int          frames   = 0;
   logic [7:0]  exp_q [$];
   int unsigned starts [$];

   // Receiver state
   int unsigned cyc_now  = 0;
   bit          in_frame = 1'b0;
   int          fpos     = 0;
   int          wave_err = 0;
   logic [7:0]  exp_byte = 8'h00;
   logic [7:0]  rx_byte  = 8'h00;
   logic        eb;

   // Every started frame has popped one queued byte, so FIFO occupancy is
   // simply bytes accepted minus frames seen on the wire.
   function automatic int fifo_cnt();
      return pushes - frames;
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [31:0] d);
      if (32'(a) < WORDS) begin
         ram_m[a[7:0]] = d;
         ram_v[a[7:0]] = 1'b1;
      end else if (a == 16'h8000) begin
         leds_m = d[7:0];
      end else if (a == 16'h8001) begin
         if (d[8] != toggle_m && fifo_cnt() < 8) begin
            exp_q.push_back(d[7:0]);
            pushes++;
            toggle_m = d[8];
         end
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #2;
         bus.dataAddress = a;
         bus.wrData      = d;
         bus.dataWrEn    = 1'b1;
         model_write(a, d);
      end
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
      @(posedge clk); #2;
      bus.dataAddress = a;
      bus.dataWrEn    = 1'b0;
      #1;
      check(tag, bus.rdData, exp);
   endtask

   task automatic rd_status(input string tag);
      int c;
      @(posedge clk); #2;
      bus.dataAddress = 16'h8002;
      bus.dataWrEn    = 1'b0;
      #1;
      c = fifo_cnt();
      check(tag, bus.rdData, {25'b0, 4'(c), in_frame, c == 8, c == 0});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #2;
         bus.dataWrEn = 1'b0;
      end
   endtask

   task automatic wait_drain(input int limit);
      int i = 0;
      while ((exp_q.size() != 0 || in_frame) && i < limit) begin
         idle(1);
         i++;
      end
      check("drain_timeout", 32'(i >= limit), 32'd0);
   endtask

   // Serial receiver: checks every cycle of each frame against the ideal
   // 8N1 waveform and decodes the byte at mid-bit.
   always @(posedge clk) begin
      #1;
      cyc_now++;
      if (rst) begin
         in_frame = 1'b0;
      end else begin
         if (in_frame && fpos == int'(FRAME)) begin
            check("txd_wave", 32'(wave_err), 32'd0);
            check("rx_byte", 32'(rx_byte), 32'(exp_byte));
            in_frame = 1'b0;
         end
         if (!in_frame && txd === 1'b0) begin
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) exp_byte = exp_q.pop_front();
            else exp_byte = 8'h00;
            in_frame = 1'b1;
            fpos     = 0;
            wave_err = 0;
            rx_byte  = 8'h00;
            frames++;
            starts.push_back(cyc_now);
         end
         if (in_frame) begin
            if (fpos < int'(CPB)) eb = 1'b0;
            else if (fpos < int'(9 * CPB)) eb = exp_byte[fpos / int'(CPB) - 1];
            else eb = 1'b1;
            if (txd !== eb) wave_err++;
            if (fpos >= int'(CPB) && fpos < int'(9 * CPB) && (fpos % int'(CPB)) == int'(CPB / 2))
               rx_byte[fpos / int'(CPB) - 1] = txd;
            fpos++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      logic [31:0] d;
      logic        t0;
      int          f0;
      int          i;

      bus.dataAddress = 16'h0000;
      bus.wrData      = 32'h0;
      bus.dataWrEn    = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_leds", 32'(leds), 32'd0);
      bus.dataAddress = 16'h8002; #1;
      check("rst_status", bus.rdData, 32'h1);
      bus.dataAddress = 16'h8001; #1;
      check("rst_txdata", bus.rdData, 32'h0);

      // Release mid-cycle; first increment lands on the next edge
      @(posedge clk); #2;
      rst = 1'b0;
      bus.dataAddress = 16'h8003; #1;
      check("cyc_after_rst", bus.rdData, 32'd0);
      rd("cyc_first_inc", 16'h8003, 32'd1);

      // RAM with held write, unmapped read
      wr(16'h0005, 32'hDEADBEEF, 3);
      rd("ram_5", 16'h0005, 32'hDEADBEEF);
      rd("unmapped_0100", 16'h0100, 32'h0);

      // Cycle counter load and wrap
      wr(16'h8003, 32'h10, 1);
      rd("cyc_load", 16'h8003, 32'h10);
      rd("cyc_inc", 16'h8003, 32'h11);
      wr(16'h8003, 32'hFFFFFFFF, 1);
      rd("cyc_load_max", 16'h8003, 32'hFFFFFFFF);
      rd("cyc_wrap", 16'h8003, 32'h0);

      // Held TXDATA write queues a single byte
      wr(16'h8001, 32'h141, 10);
      rd("txdata_toggle", 16'h8001, 32'h100);
      wait_drain(4 * FRAME);
      check("frames_single", 32'(frames), 32'd1);

      // Fill the FIFO behind a transmitting byte, then retry the overflow write
      starts.delete();
      f0 = frames;
      t0 = toggle_m;
      for (int n = 0; n < 10; n++)
         wr(16'h8001, {23'b0, (n % 2 == 0) ? ~t0 : t0, 8'(n)}, 1);
      rd("status_full", 16'h8002, 32'h46);
      rd("txdata_held", 16'h8001, 32'({~t0, 8'h00}));
      wr(16'h8001, {23'b0, t0, 8'd9}, FRAME + 20);
      rd("txdata_retry", 16'h8001, 32'({t0, 8'h00}));
      wait_drain(12 * FRAME);
      check("frames_fill", 32'(frames - f0), 32'd10);
      for (int k = 1; k < 10; k++)
         if (k < starts.size()) check("b2b_gap", starts[k] - starts[k - 1], FRAME + 1);

      // Random traffic
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 7))
            0: begin
               a = 16'($urandom_range(0, WORDS - 1));
               wr(a, $urandom, $urandom_range(1, 3));
            end
            1: begin
               a = 16'($urandom_range(0, WORDS - 1));
               if (!ram_v[a[7:0]]) a = 16'h0005;
               rd("ram_rd", a, ram_m[a[7:0]]);
            end
            2: wr(16'h8000, $urandom, $urandom_range(1, 2));
            3: begin
               rd("led_rd", 16'h8000, {24'b0, leds_m});
               check("leds_port", 32'(leds), 32'(leds_m));
            end
            4: begin
               d = {23'b0, 1'($urandom_range(0, 1)), 8'($urandom)};
               wr(16'h8001, d, $urandom_range(1, 3));
            end
            5: begin
               if ($urandom_range(0, 1) == 1) a = 16'h0100 + 16'($urandom_range(0, 16'h7EFF));
               else a = 16'h8004 + 16'($urandom_range(0, 16'h7FFB));
               if ($urandom_range(0, 1) == 1) wr(a, $urandom, 1);
               rd("unmapped_rd", a, 32'h0);
            end
            6: begin
               if ($urandom_range(0, 1) == 1) wr(16'h8002, $urandom, 1);
               rd_status("status_rd");
            end
            default: rd("txdata_rd", 16'h8001, 32'({toggle_m, 8'h00}));
         endcase
      end
      wait_drain(12 * FRAME);

      // Reset during data bit 3 with bytes queued
      wr(16'h8000, 32'hFF, 1);
      f0 = frames;
      wr(16'h8001, {23'b0, ~toggle_m, 8'hA5}, 1);
      wr(16'h8001, {23'b0, ~toggle_m, 8'h3C}, 1);
      wr(16'h8001, {23'b0, ~toggle_m, 8'h5A}, 1);
      wr(16'h8001, {23'b0, ~toggle_m, 8'hC3}, 1);
      i = 0;
      while (!(in_frame && fpos == int'(4 * CPB + CPB / 2 + 1)) && i < 500) begin
         idle(1);
         i++;
      end
      check("reach_bit3", 32'(i >= 500), 32'd0);
      check("txd_bit3", 32'(txd), 32'd0);
      #1 rst = 1'b1;
      #1;
      check("rst_txd_now", 32'(txd), 32'd1);
      check("rst_leds_now", 32'(leds), 32'd0);
      bus.dataAddress = 16'h8002; #1;
      check("rst_status_now", bus.rdData, 32'h1);
      exp_q.delete();
      pushes   = frames;
      toggle_m = 1'b0;
      leds_m   = 8'h00;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      idle(3 * FRAME);
      check("no_restart", 32'(frames - f0), 32'd1);
      check("txd_idle", 32'(txd), 32'd1);
      rd_status("status_post_rst");
      rd("txdata_post_rst", 16'h8001, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
